lc3b_mem_port: RTL and testbench
================================

Name: lc3b_mem_port

Overview:
- Memory-side stage directly downstream of the LC-3b datapath's MAR/MDR.
- Accepts word and byte requests from the datapath/control (mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata) and returns mem_resp/mem_rdata.
- Drives a word-only physical memory with a variable-latency request/response handshake.
- Byte stores (STB) become read-modify-write; a watchdog aborts stalled accesses.

Parameters:
- TIMEOUT, 255: max cycles waiting for pmem_resp per pmem access; 0 disables the watchdog. Range 0..255, 8-bit counter.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_read  in  1  read request, held until mem_resp
- mem_write  in  1  write request, held until mem_resp
- mem_byte_enable  in  2  write byte lanes; [0]=bits 7:0, [1]=bits 15:8
- mem_address  in  16  byte address (lc3b_word)
- mem_wdata  in  16  write data, already lane-replicated by the datapath
- mem_resp  out  1  one-cycle completion pulse
- mem_rdata  out  16  read data, valid while mem_resp=1
- mem_err  out  1  high with mem_resp when the access timed out
- pmem_read  out  1  physical read, held until pmem_resp
- pmem_write  out  1  physical write, held until pmem_resp
- pmem_address  out  16  word-aligned address {addr[15:1],1'b0}
- pmem_wdata  out  16  physical write data
- pmem_rdata  in  16  physical read data, valid in the pmem_resp cycle
- pmem_resp  in  1  physical completion, one cycle

Behaviour:
- Reset (async, immediate): state=IDLE. mem_resp, mem_err, pmem_read, pmem_write=0. mem_rdata, pmem_address, pmem_wdata and all capture registers=16'h0000. Watchdog counter=0. Reset mid-access abandons it; a later stray pmem_resp in IDLE is ignored.
- FSM states: IDLE, RD, RMW_RD, WR, DONE.
- IDLE: samples requests. On acceptance, capture address, wdata and byte_enable. Inputs are not used again until the next IDLE.
  - mem_read (read wins if both requests are high; write is dropped) -> RD.
  - mem_write with be=2'b11 -> WR, pmem_wdata=mem_wdata.
  - mem_write with be=2'b01 or 2'b10 -> RMW_RD.
  - mem_write with be=2'b00 -> DONE with no pmem access.
- RD / RMW_RD: pmem_read=1 until pmem_resp.
  - RD on pmem_resp: mem_rdata<=pmem_rdata -> DONE.
  - RMW_RD on pmem_resp: merge enabled lanes of the captured wdata over pmem_rdata into pmem_wdata -> WR.
- WR: pmem_write=1 until pmem_resp -> DONE.
- DONE: mem_resp=1 for exactly one cycle -> IDLE. Control drops its request on the same edge, so IDLE re-samples the following cycle.
- mem_rdata holds its last value outside DONE. Writes leave mem_rdata unchanged.
- Latency from request-high cycle to mem_resp, with physical latency L (pmem_resp L cycles after pmem strobe rises, L>=1):
  - read and full-word write: L+1
  - byte write: 2L+1
  - be=00 write: 1
- Address bit 0 is ignored for pmem_address. Reads always return the full word; the datapath selects and zero-extends the byte.
- Watchdog: counter clears on entering RD, RMW_RD or WR and increments each cycle without pmem_resp. At count==TIMEOUT (TIMEOUT>0), deassert pmem strobes -> DONE with mem_err=1 and mem_rdata=16'h0000. A timeout in RMW_RD skips the write.
- pmem_resp outside RD, RMW_RD and WR is ignored.

Optional Feature:
- Macro: LC3B_MEM_READ_BUF_EN.
- Defined: adds a one-entry read buffer (valid bit, tag=addr[15:1], 16-bit data).
  - Read hit in IDLE -> DONE directly; latency 1, no pmem access.
  - Read miss fills the buffer on pmem_resp.
  - Any completed write to the tagged word updates the buffer data with the word actually written (write-through).
  - Valid clears on rst and on any timeout.
- Undefined: no buffer; every read goes to pmem. Behaviour is otherwise identical.

Test Plan:
- Read addr 16'h3002, pmem returns 16'hBEEF with L=3 -> pmem_address=16'h3002, mem_resp pulses 4 cycles after request, mem_rdata=16'hBEEF, mem_err=0.
- STB: addr 16'h1001, be=2'b10, wdata=16'h5A5A, memory word 16'h1234 -> pmem read then pmem write of 16'h5A34 to 16'h1000, one mem_resp pulse.
- Full write 16'hCAFE to 16'h2000 with be=2'b11, L=1 -> single pmem_write, no pmem_read, mem_resp after 2 cycles.
- TIMEOUT=4 and pmem_resp never arrives -> pmem_read drops after 4 cycles, mem_resp=1 and mem_err=1, mem_rdata=0; FSM back in IDLE.
- Assert rst while in WR -> pmem_write=0 immediately, outputs zeroed; a late pmem_resp produces no mem_resp.
- LC3B_MEM_READ_BUF_EN: read 16'h4000 twice -> second read has no pmem_read and mem_resp 1 cycle later with the same data. STB to 16'h4001 then read -> buffer returns the merged word.

Source files
------------

// File: rtl/lc3b_mem_port_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_port_if
// Description : Bus bundle between the LC-3b MAR/MDR control and the memory
//               port (mem_*), and between the memory port and the word-only
//               physical memory (pmem_*).
//               master = datapath/memory environment view,
//               slave  = memory port view.
// Revision    : 1.0 - initial release
// ============================================================================
interface lc3b_mem_port_if;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_resp;
    logic [15:0] mem_rdata;
    logic        mem_err;
    logic        pmem_read;
    logic        pmem_write;
    logic [15:0] pmem_address;
    logic [15:0] pmem_wdata;
    logic [15:0] pmem_rdata;
    logic        pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        input  pmem_rdata, pmem_resp,
        output mem_resp, mem_rdata, mem_err,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_byte_enable, mem_address, mem_wdata,
        output pmem_rdata, pmem_resp,
        input  mem_resp, mem_rdata, mem_err,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lc3b_mem_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : lc3b_mem_port
// Description : Memory-side stage behind the LC-3b MAR/MDR. Turns word/byte
//               requests into word-only physical accesses; byte stores become
//               read-modify-write; a watchdog aborts stalled pmem accesses.
//               Optional one-entry read buffer when LC3B_MEM_READ_BUF_EN is
//               defined (hit returns in one cycle, writes update it).
// Revision    : 1.0 - initial release
// ============================================================================
module lc3b_mem_port #(
    parameter int unsigned TIMEOUT = 255
) (
    input  wire logic       clk,
    input  wire logic       rst,
    lc3b_mem_port_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD     = 3'd1,
        RMW_RD = 3'd2,
        WR     = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT);
    localparam bit         WD_EN       = (TIMEOUT != 0);

    state_t      state;
    logic [7:0]  wd_cnt;
    logic [15:0] wdata_q;
    logic [1:0]  be_q;
    logic        mem_resp_q;
    logic        mem_err_q;
    logic [15:0] mem_rdata_q;
    logic        pmem_read_q;
    logic        pmem_write_q;
    logic [15:0] pmem_address_q;
    logic [15:0] pmem_wdata_q;

`ifdef LC3B_MEM_READ_BUF_EN
    logic        buf_valid;
    logic [14:0] buf_tag;
    logic [15:0] buf_data;
`endif

    logic [7:0]  wd_next;
    logic        timeout_hit;
    logic [15:0] merged;

    // Watchdog fires on the cycle the count would reach the limit
    always_comb begin
        wd_next     = wd_cnt + 8'd1;
        timeout_hit = WD_EN && (wd_next == TIMEOUT_LIM);
        merged      = { be_q[1] ? wdata_q[15:8] : bus.pmem_rdata[15:8],
                        be_q[0] ? wdata_q[7:0]  : bus.pmem_rdata[7:0] };
    end

    assign bus.mem_resp     = mem_resp_q;
    assign bus.mem_err      = mem_err_q;
    assign bus.mem_rdata    = mem_rdata_q;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;

    // Request FSM with registered outputs, watchdog and optional read buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            wd_cnt         <= 8'd0;
            wdata_q        <= 16'h0000;
            be_q           <= 2'b00;
            mem_resp_q     <= 1'b0;
            mem_err_q      <= 1'b0;
            mem_rdata_q    <= 16'h0000;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= 16'h0000;
            pmem_wdata_q   <= 16'h0000;
`ifdef LC3B_MEM_READ_BUF_EN
            buf_valid      <= 1'b0;
            buf_tag        <= 15'h0000;
            buf_data       <= 16'h0000;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.mem_read || bus.mem_write) begin
                        // pmem_address doubles as the captured word address
                        pmem_address_q <= {bus.mem_address[15:1], 1'b0};
                        wdata_q        <= bus.mem_wdata;
                        be_q           <= bus.mem_byte_enable;
                        wd_cnt         <= 8'd0;
                    end
                    if (bus.mem_read) begin
`ifdef LC3B_MEM_READ_BUF_EN
                        if (buf_valid && (buf_tag == bus.mem_address[15:1])) begin
                            mem_rdata_q <= buf_data;
                            mem_resp_q  <= 1'b1;
                            state       <= DONE;
                        end else begin
                            pmem_read_q <= 1'b1;
                            state       <= RD;
                        end
`else
                        pmem_read_q <= 1'b1;
                        state       <= RD;
`endif
                    end else if (bus.mem_write) begin
                        case (bus.mem_byte_enable)
                            2'b11: begin
                                pmem_wdata_q <= bus.mem_wdata;
                                pmem_write_q <= 1'b1;
                                state        <= WR;
                            end
                            2'b00: begin
                                mem_resp_q <= 1'b1;
                                state      <= DONE;
                            end
                            default: begin
                                pmem_read_q <= 1'b1;
                                state       <= RMW_RD;
                            end
                        endcase
                    end
                end

                RD: begin
                    if (bus.pmem_resp) begin
                        pmem_read_q <= 1'b0;
                        mem_rdata_q <= bus.pmem_rdata;
                        mem_resp_q  <= 1'b1;
                        state       <= DONE;
`ifdef LC3B_MEM_READ_BUF_EN
                        buf_valid   <= 1'b1;
                        buf_tag     <= pmem_address_q[15:1];
                        buf_data    <= bus.pmem_rdata;
`endif
                    end else if (timeout_hit) begin
                        pmem_read_q <= 1'b0;
                        mem_rdata_q <= 16'h0000;
                        mem_err_q   <= 1'b1;
                        mem_resp_q  <= 1'b1;
                        state       <= DONE;
`ifdef LC3B_MEM_READ_BUF_EN
                        buf_valid   <= 1'b0;
`endif
                    end else begin
                        wd_cnt <= wd_next;
                    end
                end

                RMW_RD: begin
                    if (bus.pmem_resp) begin
                        pmem_read_q  <= 1'b0;
                        pmem_wdata_q <= merged;
                        pmem_write_q <= 1'b1;
                        wd_cnt       <= 8'd0;
                        state        <= WR;
                    end else if (timeout_hit) begin
                        // Abort skips the write half entirely
                        pmem_read_q <= 1'b0;
                        mem_rdata_q <= 16'h0000;
                        mem_err_q   <= 1'b1;
                        mem_resp_q  <= 1'b1;
                        state       <= DONE;
`ifdef LC3B_MEM_READ_BUF_EN
                        buf_valid   <= 1'b0;
`endif
                    end else begin
                        wd_cnt <= wd_next;
                    end
                end

                WR: begin
                    if (bus.pmem_resp) begin
                        pmem_write_q <= 1'b0;
                        mem_resp_q   <= 1'b1;
                        state        <= DONE;
`ifdef LC3B_MEM_READ_BUF_EN
                        if (buf_valid && (buf_tag == pmem_address_q[15:1]))
                            buf_data <= pmem_wdata_q;
`endif
                    end else if (timeout_hit) begin
                        pmem_write_q <= 1'b0;
                        mem_rdata_q  <= 16'h0000;
                        mem_err_q    <= 1'b1;
                        mem_resp_q   <= 1'b1;
                        state        <= DONE;
`ifdef LC3B_MEM_READ_BUF_EN
                        buf_valid    <= 1'b0;
`endif
                    end else begin
                        wd_cnt <= wd_next;
                    end
                end

                DONE: begin
                    mem_resp_q <= 1'b0;
                    mem_err_q  <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lc3b_mem_port.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_lc3b_mem_port
// Description : Directed self-checking bench for lc3b_mem_port with a
//               variable-latency word memory responder (TIMEOUT = 4).
//               Buffer expectations follow LC3B_MEM_READ_BUF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lc3b_mem_port;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lc3b_mem_port_if bus();

    lc3b_mem_port #(.TIMEOUT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [0:32767];
    int          lat        = 1;
    bit          hang       = 1'b0;
    logic        model_resp = 1'b0;
    logic        stray      = 1'b0;
    int          cnt        = 0;
    int          n_rd       = 0;
    int          n_wr       = 0;
    int          strobe_cyc = 0;
    logic [15:0] last_addr  = 16'h0;
    logic [15:0] last_wdata = 16'h0;

    assign bus.pmem_resp = model_resp | stray;

    // Physical memory: responds L cycles after a strobe becomes visible
    always @(negedge clk) begin
        if (model_resp) begin
            model_resp = 1'b0;
            cnt        = 0;
        end
        if (bus.pmem_read || bus.pmem_write) begin
            strobe_cyc++;
            if (!hang) begin
                cnt++;
                if (cnt == lat) begin
                    model_resp = 1'b1;
                    last_addr  = bus.pmem_address;
                    if (bus.pmem_read) begin
                        bus.pmem_rdata = mem[bus.pmem_address[15:1]];
                        n_rd++;
                    end else begin
                        mem[bus.pmem_address[15:1]] = bus.pmem_wdata;
                        last_wdata = bus.pmem_wdata;
                        n_wr++;
                    end
                    cnt = 0;
                end
            end
        end else begin
            cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One request; returns cycles to mem_resp (-1 if none) and sampled outputs
    task automatic req(input logic rd, input logic wr, input logic [1:0] be,
                       input logic [15:0] a, input logic [15:0] d,
                       output int n, output logic [15:0] rdata, output logic err);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_byte_enable = be;
        bus.mem_address     = a;
        bus.mem_wdata       = d;
        n     = -1;
        rdata = 16'h0;
        err   = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.mem_resp) begin
                n     = i;
                rdata = bus.mem_rdata;
                err   = bus.mem_err;
                break;
            end
        end
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        @(posedge clk);
        #1;
        chk("resp_one_cycle", {31'd0, bus.mem_resp}, 32'd0);
    endtask

    int          n;
    logic [15:0] rd;
    logic        er;
    int          r0, w0, s0;
    bit          seen;

    initial begin
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_byte_enable = 2'b00;
        bus.mem_address     = 16'h0;
        bus.mem_wdata       = 16'h0;
        bus.pmem_rdata      = 16'h0;
        mem[16'h3002 >> 1]  = 16'hBEEF;
        mem[16'h1000 >> 1]  = 16'h1234;
        mem[16'h4000 >> 1]  = 16'h1111;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_resp",  {31'd0, bus.mem_resp}, 32'd0);
        chk("rst_mem_err",   {31'd0, bus.mem_err}, 32'd0);
        chk("rst_strobes",   {30'd0, bus.pmem_read, bus.pmem_write}, 32'd0);
        chk("rst_mem_rdata", {16'd0, bus.mem_rdata}, 32'h0);
        chk("rst_pmem_addr", {16'd0, bus.pmem_address}, 32'h0);
        chk("rst_pmem_wdata",{16'd0, bus.pmem_wdata}, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Word read, L=3
        lat = 3; r0 = n_rd;
        req(1'b1, 1'b0, 2'b11, 16'h3002, 16'h0, n, rd, er);
        chk("rd_latency", n, 4);
        chk("rd_data", {16'd0, rd}, 32'hBEEF);
        chk("rd_err", {31'd0, er}, 32'd0);
        chk("rd_addr", {16'd0, last_addr}, 32'h3002);
        chk("rd_pmem_reads", n_rd - r0, 1);

        // STB high lane, L=2
        lat = 2; r0 = n_rd; w0 = n_wr;
        req(1'b0, 1'b1, 2'b10, 16'h1001, 16'h5A5A, n, rd, er);
        chk("stb_latency", n, 5);
        chk("stb_reads", n_rd - r0, 1);
        chk("stb_writes", n_wr - w0, 1);
        chk("stb_wdata", {16'd0, last_wdata}, 32'h5A34);
        chk("stb_addr", {16'd0, last_addr}, 32'h1000);
        chk("stb_rdata_kept", {16'd0, bus.mem_rdata}, 32'hBEEF);
        chk("stb_err", {31'd0, er}, 32'd0);

        // Full-word write, L=1
        lat = 1; r0 = n_rd; w0 = n_wr;
        req(1'b0, 1'b1, 2'b11, 16'h2000, 16'hCAFE, n, rd, er);
        chk("wr_latency", n, 2);
        chk("wr_reads", n_rd - r0, 0);
        chk("wr_writes", n_wr - w0, 1);
        chk("wr_wdata", {16'd0, last_wdata}, 32'hCAFE);

        // be=00 write: no physical access
        r0 = n_rd; w0 = n_wr;
        req(1'b0, 1'b1, 2'b00, 16'h5000, 16'h9999, n, rd, er);
        chk("be00_latency", n, 1);
        chk("be00_access", (n_rd - r0) + (n_wr - w0), 0);

        // Read and write together: read wins
        w0 = n_wr;
        req(1'b1, 1'b1, 2'b11, 16'h2000, 16'hFFFF, n, rd, er);
        chk("both_latency", n, 2);
        chk("both_data", {16'd0, rd}, 32'hCAFE);
        chk("both_no_write", n_wr - w0, 0);

        // STB low lane, L=1
        req(1'b0, 1'b1, 2'b01, 16'h2000, 16'h7777, n, rd, er);
        chk("stb_lo_latency", n, 3);
        chk("stb_lo_wdata", {16'd0, last_wdata}, 32'hCA77);

        // Read timeout
        hang = 1'b1; s0 = strobe_cyc;
        req(1'b1, 1'b0, 2'b11, 16'h3002, 16'h0, n, rd, er);
        chk("to_latency", n, 5);
        chk("to_err", {31'd0, er}, 32'd1);
        chk("to_rdata", {16'd0, rd}, 32'h0);
        chk("to_strobe_cycles", strobe_cyc - s0, 4);
        chk("to_idle", {30'd0, bus.mem_err, bus.pmem_read}, 32'd0);

        // Timeout in RMW read skips the write
        w0 = n_wr;
        req(1'b0, 1'b1, 2'b01, 16'h1001, 16'h00AB, n, rd, er);
        chk("rmw_to_latency", n, 5);
        chk("rmw_to_err", {31'd0, er}, 32'd1);
        chk("rmw_to_no_write", n_wr - w0, 0);

        // Reset while in WR
        bus.mem_write = 1'b1; bus.mem_byte_enable = 2'b11;
        bus.mem_address = 16'h2000; bus.mem_wdata = 16'hDEAD;
        repeat (2) begin @(posedge clk); #1; end
        chk("wr_strobe_before_rst", {31'd0, bus.pmem_write}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_async_write", {31'd0, bus.pmem_write}, 32'd0);
        chk("rst_async_wdata", {16'd0, bus.pmem_wdata}, 32'h0);
        chk("rst_async_addr", {16'd0, bus.pmem_address}, 32'h0);
        bus.mem_write = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; hang = 1'b0; stray = 1'b1;
        @(posedge clk); #1;
        stray = 1'b0;
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus.mem_resp || bus.pmem_read || bus.pmem_write) seen = 1'b1;
        end
        chk("stray_resp_ignored", {31'd0, seen}, 32'd0);

        // Normal operation after reset
        lat = 1;
        req(1'b1, 1'b0, 2'b11, 16'h3002, 16'h0, n, rd, er);
        chk("post_rst_latency", n, 2);
        chk("post_rst_data", {16'd0, rd}, 32'hBEEF);

        // Repeated read, then STB and read back (buffer-dependent latency)
        lat = 2;
        req(1'b1, 1'b0, 2'b11, 16'h4000, 16'h0, n, rd, er);
        chk("buf_first_latency", n, 3);
        chk("buf_first_data", {16'd0, rd}, 32'h1111);
        r0 = n_rd;
        req(1'b1, 1'b0, 2'b11, 16'h4000, 16'h0, n, rd, er);
        chk("buf_second_data", {16'd0, rd}, 32'h1111);
`ifdef LC3B_MEM_READ_BUF_EN
        chk("buf_second_latency", n, 1);
        chk("buf_second_reads", n_rd - r0, 0);
`else
        chk("buf_second_latency", n, 3);
        chk("buf_second_reads", n_rd - r0, 1);
`endif
        req(1'b0, 1'b1, 2'b10, 16'h4001, 16'hAAAA, n, rd, er);
        chk("buf_stb_latency", n, 5);
        chk("buf_stb_wdata", {16'd0, last_wdata}, 32'hAA11);
        req(1'b1, 1'b0, 2'b11, 16'h4000, 16'h0, n, rd, er);
        chk("buf_merged_data", {16'd0, rd}, 32'hAA11);
`ifdef LC3B_MEM_READ_BUF_EN
        chk("buf_merged_latency", n, 1);
`else
        chk("buf_merged_latency", n, 3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed=stuck expected=finish");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire
